// File: rtl/dcache_pkg.sv
// Shared dcache definitions: opcode codes, ROB tag type, default I/O port address.
// Also small opcode decode helpers (access length, store flag) used at request accept.
// No ports; imported by dcache_if and dcache.
package dcache_pkg;

  localparam int ROB_W = 4;
  typedef logic [ROB_W-1:0] robid_t;

  // Memory-mapped UART data port; stores here are throttled by io_buffer_full.
  localparam logic [31:0] IO_ADDR_DEF = 32'h0003_0000;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Number of byte transactions for an access.
  function automatic logic [2:0] op_len(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache bus bundle: LSB request/ack, CDBD load broadcast, byte-wide RAM arbiter port.
// master = the dcache side (drives ack, broadcast and bus request); slave = LSB/CDB/arbiter side.
// Signals keep their system-level names so waveforms line up with the rest of the core.
interface dcache_if;
  import dcache_pkg::*;

  logic        LSB_sgn;
  logic [31:0] LSB_addr;
  logic [31:0] LSB_val;
  logic [5:0]  LSB_opcode;
  robid_t      LSB_ROB_name;
  logic        LSB_done;

  logic        CDBD_sgn;
  logic [31:0] CDBD_result;
  robid_t      CDBD_ROB_name;

  logic        MEM_req;
  logic        MEM_gnt;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  modport master (
    input  LSB_sgn, LSB_addr, LSB_val, LSB_opcode, LSB_ROB_name, MEM_gnt, mem_din,
    output LSB_done, CDBD_sgn, CDBD_result, CDBD_ROB_name, MEM_req, mem_a, mem_wr, mem_dout
  );

  modport slave (
    output LSB_sgn, LSB_addr, LSB_val, LSB_opcode, LSB_ROB_name, MEM_gnt, mem_din,
    input  LSB_done, CDBD_sgn, CDBD_result, CDBD_ROB_name, MEM_req, mem_a, mem_wr, mem_dout
  );

endinterface

// File: rtl/dcache.sv
// Memory-access unit: runs one LSB load/store as 1/2/4 little-endian byte bus transactions.
// Ports: clk, rst (sync, active high), rdy (global enable), io_buffer_full, jp_wrong, bus (dcache_if.master).
// Latency with continuous grant: LW 6, LB 3, SW 5, SB 2 cycles after accept; each gnt-low/IO-stall cycle adds one.
module dcache
  import dcache_pkg::*;
#(
  parameter logic [31:0] IO_ADDR = IO_ADDR_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     io_buffer_full,
  input  logic     jp_wrong,
  dcache_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_TAIL, S_DONE} state_t;

  state_t          state_q, state_n;
  logic [31:0]     addr_q;
  logic [31:0]     val_q;
  logic [5:0]      op_q;
  robid_t          tag_q;
  logic [2:0]      len_q;
  logic [2:0]      cnt_q;
  logic            store_q;
  logic            pend_q;      // a read address went out last cycle
  logic [1:0]      pend_idx_q;  // which byte that read returns
  logic [3:0][7:0] rbuf_q;

  logic [31:0] byte_a;
  logic        in_bus;
  logic        io_stall;
  logic        abort;
  logic        issue;
  logic        last;
  logic        fire;

  function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [31:0] raw);
    case (op)
      OP_LB:   return {{24{raw[7]}}, raw[7:0]};
      OP_LH:   return {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  return {24'd0, raw[7:0]};
      OP_LHU:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign byte_a   = addr_q + {29'd0, cnt_q};
  assign in_bus   = (state_q == S_REQ) || (state_q == S_XFER);
  assign io_stall = store_q && (byte_a == IO_ADDR) && io_buffer_full;
  // Stores are already committed by the ROB, so only loads are squashed.
  assign abort    = !store_q && jp_wrong && (in_bus || (state_q == S_TAIL));
  assign issue    = rdy && in_bus && bus.MEM_gnt && !io_stall && !abort;
  assign last     = (cnt_q == len_q - 3'd1);
  assign fire     = rdy && (state_q == S_DONE) && !(jp_wrong && !store_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (rdy) begin
      state_q <= state_n;
    end
  end

  // Next-state logic. Byte 0 issues in REQ itself, so a one-byte access
  // leaves REQ straight for TAIL (load) or DONE (store).
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (bus.LSB_sgn) state_n = S_REQ;
      S_REQ, S_XFER: begin
        if (abort)                state_n = S_IDLE;
        else if (issue && last)   state_n = store_q ? S_DONE : S_TAIL;
        else if (bus.MEM_gnt)     state_n = S_XFER;
      end
      S_TAIL:  state_n = abort ? S_IDLE : S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs: bus fields are zero unless a byte is actually issued this cycle.
  always_comb begin
    bus.MEM_req       = in_bus;
    bus.mem_wr        = issue && store_q;
    bus.mem_a         = issue ? byte_a : 32'd0;
    bus.mem_dout      = (issue && store_q) ? val_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
    bus.LSB_done      = fire;
    bus.CDBD_sgn      = fire && !store_q;
    bus.CDBD_result   = (fire && !store_q) ? load_ext(op_q, rbuf_q) : 32'd0;
    bus.CDBD_ROB_name = (fire && !store_q) ? tag_q : '0;
  end

  // Request latch, byte counter and read-return capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      val_q      <= '0;
      op_q       <= '0;
      tag_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      store_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      rbuf_q     <= '0;
    end else if (rdy) begin
      if ((state_q == S_IDLE) && bus.LSB_sgn) begin
        addr_q  <= bus.LSB_addr;
        val_q   <= bus.LSB_val;
        op_q    <= bus.LSB_opcode;
        tag_q   <= bus.LSB_ROB_name;
        len_q   <= op_len(bus.LSB_opcode);
        store_q <= op_is_store(bus.LSB_opcode);
        cnt_q   <= '0;
      end else if (issue) begin
        cnt_q <= cnt_q + 3'd1;
      end
      // mem_din answers the address of the previous cycle; only real
      // read issues are tracked so gnt gaps never capture stale data.
      pend_q     <= issue && !store_q;
      pend_idx_q <= cnt_q[1:0];
      if (pend_q) rbuf_q[pend_idx_q] <= bus.mem_din;
    end
  end

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic io_buffer_full;
  logic jp_wrong;

  dcache_if bus();

  dcache #(.IO_ADDR(IO_ADDR_DEF)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .io_buffer_full(io_buffer_full), .jp_wrong(jp_wrong),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit [7:0] ram     [bit [31:0]];  // what the DUT actually wrote
  bit [7:0] ref_mem [bit [31:0]];  // what the reference says memory should hold
  logic [7:0] rd_stash = 8'd0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] val;
    logic [3:0]  tag;
    bit          pre;
    logic [31:0] pre_w;
    logic [31:0] exp_res;
    int          lat;
  } vec_t;

  vec_t tab[14];

  function automatic bit [7:0] dflt(input bit [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction
  function automatic bit [7:0] ram_get(input bit [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic bit [7:0] ref_get(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic int oplen(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction
  function automatic bit is_st(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Little-endian assembly from the reference memory, then two's-complement
  // reinterpretation for the signed opcodes.
  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
    longint v = 0;
    int n = oplen(op);
    for (int i = 0; i < n; i++) v += longint'(ref_get(a + 32'(i))) << (8 * i);
    if ((op == OP_LB || op == OP_LH) && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
    return 32'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM/arbiter model: writes land in the cycle they are issued; read data
  // appears on mem_din for the whole following cycle.
  task automatic bus_settle();
    bus.mem_din = rd_stash;
    #1;
    if (bus.MEM_gnt && bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    if (bus.MEM_gnt && !bus.mem_wr) rd_stash = ram_get(bus.mem_a);
    else rd_stash = 8'($urandom);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ram[a + 32'(i)]     = 8'(w >> (8 * i));
      ref_mem[a + 32'(i)] = 8'(w >> (8 * i));
    end
  endtask

  // One request. Cycle 0 is the IDLE cycle that accepts it. Per-cycle
  // expectations come from counting issued bytes against the grant,
  // IO-stall, rdy and flush patterns.
  task automatic run_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] val,
                         input logic [3:0] tag, input bit [63:0] gpat, input bit [63:0] iopat,
                         input bit [63:0] rpat, input int jp_cyc, input bit use_tab,
                         input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit st;
    logic [31:0] eres;
    int k;
    int done_c;
    int obs_done;
    bit fin;
    n = oplen(op);
    st = is_st(op);
    eres = use_tab ? exp_res : model_load(op, addr);
    if (st) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'(val >> (8 * i));

    @(negedge clk);
    bus.LSB_sgn = 1'b1; bus.LSB_addr = addr; bus.LSB_val = val;
    bus.LSB_opcode = op; bus.LSB_ROB_name = tag;
    bus.MEM_gnt = gpat[0]; io_buffer_full = 1'b0; jp_wrong = 1'b0; rdy = 1'b1;
    bus_settle();
    chk("idle_mem_req", 32'(bus.MEM_req), 32'd0);
    chk("idle_lsb_done", 32'(bus.LSB_done), 32'd0);
    chk("idle_cdbd_sgn", 32'(bus.CDBD_sgn), 32'd0);

    k = 0; done_c = -1; obs_done = -1; fin = 1'b0;
    for (int c = 1; c < 64 && !fin; c++) begin
      bit jp_now, stall, iss, dn;
      @(negedge clk);
      bus.MEM_gnt = gpat[c]; io_buffer_full = iopat[c]; rdy = rpat[c]; jp_wrong = (c == jp_cyc);
      bus_settle();
      if (bus.LSB_done && obs_done < 0) obs_done = c;
      jp_now = !st && (c == jp_cyc);
      stall  = st && (k < n) && ((addr + 32'(k)) == IO_ADDR_DEF) && iopat[c];
      iss    = (k < n) && gpat[c] && rpat[c] && !stall && !jp_now;
      chk("mem_req", 32'(bus.MEM_req), 32'(k < n));
      chk("mem_wr", 32'(bus.mem_wr), 32'(st && iss));
      if (iss) begin
        chk("mem_a", bus.mem_a, addr + 32'(k));
        if (st) chk("mem_dout", 32'(bus.mem_dout), (val >> (8 * k)) & 32'hFF);
      end
      dn = (c == done_c) && !jp_now;
      chk("lsb_done", 32'(bus.LSB_done), 32'(dn));
      chk("cdbd_sgn", 32'(bus.CDBD_sgn), 32'(dn && !st));
      if (dn && !st) begin
        chk("cdbd_result", bus.CDBD_result, eres);
        chk("cdbd_tag", 32'(bus.CDBD_ROB_name), 32'(tag));
      end
      if (c == done_c || (jp_now && (done_c < 0 || c < done_c))) fin = 1'b1;
      else if (iss) begin
        k++;
        if (k == n) done_c = c + (st ? 1 : 2);
      end
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL timeout: request op=%0d addr=%h never completed", op, addr);
    end
    if (exp_lat >= 0) chk("latency", 32'(obs_done), 32'(exp_lat));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit [63:0] ones, zero, g, io, r;
    ones = '1; zero = '0;

    tab[0]  = '{OP_LW,  32'h100,      32'h0,        4'h3, 1'b1, 32'h12345678, 32'h12345678, 6};
    tab[1]  = '{OP_LB,  32'h200,      32'h0,        4'h5, 1'b1, 32'h0000FF80, 32'hFFFFFF80, 3};
    tab[2]  = '{OP_LBU, 32'h200,      32'h0,        4'h6, 1'b0, 32'h0,        32'h00000080, 3};
    tab[3]  = '{OP_LHU, 32'h200,      32'h0,        4'h7, 1'b0, 32'h0,        32'h0000FF80, 4};
    tab[4]  = '{OP_LH,  32'h200,      32'h0,        4'h8, 1'b0, 32'h0,        32'hFFFFFF80, 4};
    tab[5]  = '{OP_SW,  32'h300,      32'hDEADBEEF, 4'h9, 1'b0, 32'h0,        32'h0,        5};
    tab[6]  = '{OP_LW,  32'h300,      32'h0,        4'hA, 1'b0, 32'h0,        32'hDEADBEEF, 6};
    tab[7]  = '{OP_LW,  32'h301,      32'h0,        4'hB, 1'b0, 32'h0,        32'h5EDEADBE, 6};
    tab[8]  = '{OP_SB,  32'h305,      32'h123456A5, 4'h1, 1'b0, 32'h0,        32'h0,        2};
    tab[9]  = '{OP_LBU, 32'h305,      32'h0,        4'hC, 1'b0, 32'h0,        32'h000000A5, 3};
    tab[10] = '{OP_SH,  32'hFFFFFFFF, 32'h00001234, 4'h2, 1'b0, 32'h0,        32'h0,        3};
    tab[11] = '{OP_LHU, 32'hFFFFFFFF, 32'h0,        4'hD, 1'b0, 32'h0,        32'h00001234, 4};
    tab[12] = '{OP_LB,  32'hFFFFFFFF, 32'h0,        4'hE, 1'b0, 32'h0,        32'h00000034, 3};
    tab[13] = '{OP_LH,  32'h302,      32'h0,        4'hF, 1'b0, 32'h0,        32'hFFFFDEAD, 4};

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; jp_wrong = 1'b0;
    bus.LSB_sgn = 1'b0; bus.LSB_addr = '0; bus.LSB_val = '0; bus.LSB_opcode = '0;
    bus.LSB_ROB_name = '0; bus.MEM_gnt = 1'b0; bus.mem_din = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_lsb_done", 32'(bus.LSB_done), 32'd0);
    chk("rst_cdbd_sgn", 32'(bus.CDBD_sgn), 32'd0);
    chk("rst_cdbd_result", bus.CDBD_result, 32'd0);
    chk("rst_cdbd_tag", 32'(bus.CDBD_ROB_name), 32'd0);
    chk("rst_mem_req", 32'(bus.MEM_req), 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, full grant, back to back.
    for (int i = 0; i < 14; i++) begin
      if (tab[i].pre) preload(tab[i].addr, tab[i].pre_w);
      run_req(tab[i].op, tab[i].addr, tab[i].val, tab[i].tag, ones, zero, ones, -1,
              1'b1, tab[i].exp_res, tab[i].lat);
    end

    // LH with grant toggling: one low cycle inside the transfer.
    g = ones; g[2] = 1'b0;
    run_req(OP_LH, 32'h200, 32'h0, 4'h4, g, zero, ones, -1, 1'b1, 32'hFFFFFF80, 5);

    // Flushed LW mid-transfer, then an SH that must complete normally.
    run_req(OP_LW, 32'h100, 32'h0, 4'h3, ones, zero, ones, 3, 1'b1, 32'h0, -1);
    run_req(OP_SH, 32'h500, 32'h0000BEEF, 4'h2, ones, zero, ones, -1, 1'b1, 32'h0, 3);
    run_req(OP_LHU, 32'h500, 32'h0, 4'h6, ones, zero, ones, -1, 1'b1, 32'h0000BEEF, 4);

    // Flush in DONE, then in TAIL, then an undisturbed load.
    run_req(OP_LB, 32'h200, 32'h0, 4'h1, ones, zero, ones, 3, 1'b1, 32'h0, -1);
    run_req(OP_LB, 32'h200, 32'h0, 4'h1, ones, zero, ones, 2, 1'b1, 32'h0, -1);
    run_req(OP_LBU, 32'h200, 32'h0, 4'h9, ones, zero, ones, -1, 1'b1, 32'h00000080, 3);

    // UART store held off for three cycles, then read back.
    io = zero; io[1] = 1'b1; io[2] = 1'b1; io[3] = 1'b1;
    run_req(OP_SB, IO_ADDR_DEF, 32'h00000041, 4'h0, ones, io, ones, -1, 1'b1, 32'h0, 5);
    run_req(OP_LBU, IO_ADDR_DEF, 32'h0, 4'h5, ones, zero, ones, -1, 1'b1, 32'h00000041, 3);

    // rdy low for two cycles during a store.
    r = ones; r[2] = 1'b0; r[3] = 1'b0;
    run_req(OP_SW, 32'h310, 32'hCAFEF00D, 4'h0, ones, zero, r, -1, 1'b1, 32'h0, 7);
    run_req(OP_LW, 32'h310, 32'h0, 4'h7, ones, zero, ones, -1, 1'b1, 32'hCAFEF00D, 6);

    // A store ignores the flush.
    run_req(OP_SB, 32'h320, 32'h00000077, 4'h0, ones, zero, ones, 1, 1'b1, 32'h0, 2);
    run_req(OP_LBU, 32'h320, 32'h0, 4'h8, ones, zero, ones, -1, 1'b1, 32'h00000077, 3);

    // Randomized traffic against the reference memory.
    for (int t = 0; t < 60; t++) begin
      logic [5:0] op;
      logic [31:0] a;
      int jp;
      op = 6'($urandom_range(1, 8));
      a = 32'h300 + 32'($urandom_range(0, 15));
      if (is_st(op) && $urandom_range(0, 7) == 0) a = IO_ADDR_DEF;
      for (int i = 0; i < 64; i++) begin
        g[i]  = (i >= 40) || ($urandom_range(0, 3) != 0);
        io[i] = (i < 40) && ($urandom_range(0, 1) == 1);
      end
      jp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
      run_req(op, a, $urandom, 4'($urandom), g, io, ones, jp, 1'b0, 32'h0, -1);
    end

    @(negedge clk);
    bus.LSB_sgn = 1'b0; jp_wrong = 1'b0; io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
